// File: rtl/serial_adder_ctrl.sv
// Bit-serial add sequencer: drives one external full adder LSB-first, keeps the
// carry in a register between bits and assembles the WIDTH-bit sum plus final carry.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start; sum/cout hold the last result
// S_SHIFT | one operand bit pair per cycle through the full adder (busy=1)
// S_DONE  | one-cycle done pulse, then back to S_IDLE
module serial_adder_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             fa_i0,
  output logic             fa_i1,
  output logic             fa_ci,
  input  logic             fa_s,
  input  logic             fa_co
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [WIDTH-1:0]  a_sh;
  logic [WIDTH-1:0]  b_sh;
  logic              carry;
  logic [CW-1:0]     cnt;
  logic              last_bit;

  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      carry   <= 1'b0;
      cnt     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
          end
        end
        S_SHIFT: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          sum   <= {fa_s, sum[WIDTH-1:1]};
          carry <= fa_co;
          // cnt parks at 0 after the last bit so it never wraps
          if (last_bit) begin
            cout <= fa_co;
            cnt  <= '0;
          end else begin
            cnt  <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    fa_i0   = 1'b0;
    fa_i1   = 1'b0;
    fa_ci   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        busy  = 1'b1;
        fa_i0 = a_sh[0];
        fa_i1 = b_sh[0];
        fa_ci = carry;
        if (last_bit) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized and directed bench for serial_adder_ctrl (WIDTH=8 and WIDTH=4 instances),
// each wired to a gate-level full adder; results come from plain integer arithmetic.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // WIDTH=8 instance
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       fa_i0_8, fa_i1_8, fa_ci_8, fa_s_8, fa_co_8;
  logic       g1_8, g2_8, g3_8;

  xor (fa_s_8, fa_i0_8, fa_i1_8, fa_ci_8);
  and (g1_8, fa_i0_8, fa_i1_8);
  and (g2_8, fa_i0_8, fa_ci_8);
  and (g3_8, fa_i1_8, fa_ci_8);
  or  (fa_co_8, g1_8, g2_8, g3_8);

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8),
    .fa_i0(fa_i0_8), .fa_i1(fa_i1_8), .fa_ci(fa_ci_8), .fa_s(fa_s_8), .fa_co(fa_co_8)
  );

  // WIDTH=4 instance
  logic       start4, cin4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;
  logic       fa_i0_4, fa_i1_4, fa_ci_4, fa_s_4, fa_co_4;
  logic       g1_4, g2_4, g3_4;

  xor (fa_s_4, fa_i0_4, fa_i1_4, fa_ci_4);
  and (g1_4, fa_i0_4, fa_i1_4);
  and (g2_4, fa_i0_4, fa_ci_4);
  and (g3_4, fa_i1_4, fa_ci_4);
  or  (fa_co_4, g1_4, g2_4, g3_4);

  serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4),
    .fa_i0(fa_i0_4), .fa_i1(fa_i1_4), .fa_ci(fa_ci_4), .fa_s(fa_s_4), .fa_co(fa_co_4)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One WIDTH=8 add; restart_k>0 pulses start with other operands in that SHIFT cycle.
  task automatic do_add8(input logic [7:0] oa, input logic [7:0] ob, input logic ocin,
                         input int restart_k);
    int     k;
    int     busy_n;
    longint m;
    longint exp_ci;
    longint exp_fa;
    longint total;
    total  = longint'(oa) + longint'(ob) + longint'(ocin);
    a8     = oa;
    b8     = ob;
    cin8   = ocin;
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    k      = 1;
    busy_n = 0;
    while (!done8 && k <= 11) begin
      if (busy8) begin
        busy_n++;
        if (k <= 8) begin
          m      = (longint'(1) << (k - 1)) - 1;
          exp_ci = (((longint'(oa) & m) + (longint'(ob) & m) + longint'(ocin)) >> (k - 1)) & 1;
          exp_fa = (((longint'(oa) >> (k - 1)) & 1) << 2) | (((longint'(ob) >> (k - 1)) & 1) << 1) | exp_ci;
          check("fa_bits", {fa_i0_8, fa_i1_8, fa_ci_8}, exp_fa);
        end
      end
      if (k == restart_k) begin
        start8 = 1'b1;
        a8     = 8'hF0;
        b8     = 8'h0F;
        cin8   = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      step();
      k++;
    end
    start8 = 1'b0;
    check("done_latency", k, 9);
    check("busy_cycles", busy_n, 8);
    check("sum8", sum8, total & 8'hFF);
    check("cout8", cout8, (total >> 8) & 1);
    step();
    check("done_one_cycle", {done8, busy8}, 0);
    check("sum8_hold", sum8, total & 8'hFF);
  endtask

  task automatic do_add4(input logic [3:0] oa, input logic [3:0] ob, input logic ocin);
    int k;
    a4     = oa;
    b4     = ob;
    cin4   = ocin;
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    k      = 1;
    while (!done4 && k <= 8) begin
      step();
      k++;
    end
    check("done_latency4", k, 5);
    check("sum4", {cout4, sum4}, longint'(oa) + longint'(ob) + longint'(ocin));
    step();
  endtask

  initial begin
    int done_cyc[$];
    int bad_sum;
    int pulses;
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("reset8", {busy8, done8, sum8, cout8, fa_i0_8, fa_i1_8, fa_ci_8}, 0);
    check("reset4", {busy4, done4, sum4, cout4, fa_i0_4, fa_i1_4, fa_ci_4}, 0);

    do_add8(8'h5A, 8'h3C, 1'b0, 0);
    do_add8(8'hFF, 8'h01, 1'b0, 0);
    do_add8(8'hFF, 8'hFF, 1'b1, 0);
    do_add8(8'h00, 8'h00, 1'b0, 0);
    do_add8(8'h01, 8'h01, 1'b0, 3);
    check("restart_ignored", {cout8, sum8}, 9'h002);

    for (int i = 0; i < 40; i++) begin
      do_add8(8'($urandom), 8'($urandom), 1'($urandom), 0);
    end

    // reset in the middle of an add
    a8 = 8'h77; b8 = 8'h19; cin8 = 1'b1; start8 = 1'b1;
    step();
    start8 = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_outputs", {busy8, done8, sum8, cout8, fa_i0_8, fa_i1_8, fa_ci_8}, 0);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      if (done8 || busy8) pulses++;
      step();
    end
    check("abort_no_done", pulses, 0);

    // start held high: back-to-back adds
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
    bad_sum = 0;
    for (int c = 1; c <= 45; c++) begin
      step();
      if (done8) begin
        done_cyc.push_back(c);
        check("held_result", {cout8, sum8}, 9'h100);
      end
      if (done_cyc.size() > 0 && sum8 != 8'h00) bad_sum++;
    end
    start8 = 1'b0;
    check("held_done_count", done_cyc.size(), 4);
    check("held_first_done", (done_cyc.size() > 0) ? done_cyc[0] : -1, 9);
    for (int i = 1; i < done_cyc.size(); i++) begin
      check("held_period", done_cyc[i] - done_cyc[i-1], 10);
    end
    check("held_sum_stable", bad_sum, 0);
    for (int i = 0; i < 12; i++) step();

    // WIDTH=4 exhaustive
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        for (int z = 0; z < 2; z++) begin
          do_add4(4'(x), 4'(y), 1'(z));
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
